// File: rtl/router_dest_reader.sv
// router_dest_reader
//   Destination-side consumer for one router output FIFO. Pulls one packet
//   at a time through the FIFO read handshake (header, payload, parity),
//   reports the header fields, streams payload bytes out, checks parity and
//   flags completion or abort.
//
//   Packet: {len[5:0], addr[1:0]}, len payload bytes, parity byte equal to
//   the XOR of the header and every payload byte.
//
// Ports
//   clk, resetn         clock (rising edge), asynchronous active-low reset
//   soft_reset          synchronous flush/abort from the router timeout
//   valid_out           FIFO non-empty
//   data_out[7:0]       FIFO read data, valid the cycle after an accepted read
//   read_enb            FIFO read request (combinational)
//   busy                high whenever the reader is not IDLE
//   hdr_valid           one-cycle pulse with hdr_len / hdr_addr updated
//   hdr_len, hdr_addr   header fields, held until the next header
//   byte_valid          one-cycle pulse per payload byte on byte_data
//   pkt_done            one-cycle pulse on parity byte, parity_err qualified
//   pkt_abort           one-cycle pulse when soft_reset kills a packet
module router_dest_reader #(
    parameter int START_DELAY = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       soft_reset,
    input  logic       valid_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic       busy,
    output logic       hdr_valid,
    output logic [5:0] hdr_len,
    output logic [1:0] hdr_addr,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       pkt_abort
);

    typedef enum logic [2:0] {IDLE, DELAY, HDR_RD, HDR_CAP, BODY} state_t;

    localparam logic [4:0] DLY_INIT = 5'(START_DELAY);

    state_t     state_q, state_d;
    logic [4:0] dly_q, dly_d;
    logic [6:0] issue_q, issue_d;   // reads still to issue in BODY
    logic [6:0] recv_q, recv_d;     // bytes still to receive in BODY
    logic [7:0] acc_q, acc_d;       // running parity
    logic       got_q, got_d;       // data_out carries a sampled byte
    logic       hdr_valid_q, hdr_valid_d;
    logic [5:0] hdr_len_q, hdr_len_d;
    logic [1:0] hdr_addr_q, hdr_addr_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       pkt_done_q, pkt_done_d;
    logic       parity_err_q, parity_err_d;
    logic       pkt_abort_q, pkt_abort_d;
    logic       rd;

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        issue_d      = issue_q;
        recv_d       = recv_q;
        acc_d        = acc_q;
        hdr_len_d    = hdr_len_q;
        hdr_addr_d   = hdr_addr_q;
        byte_data_d  = byte_data_q;
        hdr_valid_d  = 1'b0;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        pkt_abort_d  = 1'b0;
        rd           = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_out) begin
                    if (START_DELAY == 0) begin
                        state_d = HDR_RD;
                    end else begin
                        dly_d   = DLY_INIT;
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (dly_q <= 5'd1) begin
                    dly_d   = 5'd0;
                    state_d = HDR_RD;
                end else begin
                    dly_d = dly_q - 5'd1;
                end
            end
            HDR_RD: begin
                rd = 1'b1;
                if (valid_out) state_d = HDR_CAP;
            end
            HDR_CAP: begin
                // Header byte is on data_out now; len+1 covers payload plus parity.
                hdr_len_d   = data_out[7:2];
                hdr_addr_d  = data_out[1:0];
                acc_d       = data_out;
                hdr_valid_d = 1'b1;
                issue_d     = {1'b0, data_out[7:2]} + 7'd1;
                recv_d      = {1'b0, data_out[7:2]} + 7'd1;
                state_d     = BODY;
            end
            BODY: begin
                rd = (issue_q != 7'd0);
                if (rd && valid_out) issue_d = issue_q - 7'd1;
                if (got_q) begin
                    recv_d = recv_q - 7'd1;
                    if (recv_q > 7'd1) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = data_out;
                        acc_d        = acc_q ^ data_out;
                    end else begin
                        pkt_done_d   = 1'b1;
                        parity_err_d = (acc_q != data_out);
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything; any byte in flight is dropped.
        if (soft_reset) begin
            rd           = 1'b0;
            state_d      = IDLE;
            dly_d        = 5'd0;
            issue_d      = 7'd0;
            recv_d       = 7'd0;
            acc_d        = 8'd0;
            hdr_valid_d  = 1'b0;
            byte_valid_d = 1'b0;
            pkt_done_d   = 1'b0;
            parity_err_d = 1'b0;
            pkt_abort_d  = (state_q != IDLE);
        end

        got_d = rd && valid_out;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            dly_q        <= 5'd0;
            issue_q      <= 7'd0;
            recv_q       <= 7'd0;
            acc_q        <= 8'd0;
            got_q        <= 1'b0;
            hdr_valid_q  <= 1'b0;
            hdr_len_q    <= 6'd0;
            hdr_addr_q   <= 2'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            pkt_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            issue_q      <= issue_d;
            recv_q       <= recv_d;
            acc_q        <= acc_d;
            got_q        <= got_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_len_q    <= hdr_len_d;
            hdr_addr_q   <= hdr_addr_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            pkt_abort_q  <= pkt_abort_d;
        end
    end

    assign read_enb   = rd;
    assign busy       = (state_q != IDLE);
    assign hdr_valid  = hdr_valid_q;
    assign hdr_len    = hdr_len_q;
    assign hdr_addr   = hdr_addr_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign pkt_abort  = pkt_abort_q;

endmodule
